shared_reg_arbiter: RTL and testbench

- Round-robin write arbiter sharing one `register` instance (`d_i`, `ld_i`) among `n_req` requesters.
- Each requester presents a write word with a request.
- The block selects one requester and drives `ld_o`/`d_o` into the register's `ld_i`/`d_i` for one cycle.
- It then returns a one-cycle `ack_o` pulse to the winner.
- Sits between producer blocks and the shared register.

---
 rtl/shared_reg_arbiter.sv | 160 ++++++++++++++++
 tb/tb_shared_reg_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter that shares one register (ld/d) among n_req producers.
// Optional macro SHARED_REG_ARB_LOCK_EN adds lock_i for atomic multi-write bursts.
module shared_reg_arbiter #(
  parameter int lsize = 8,
  parameter int n_req = 4,
  localparam int IW   = $clog2(n_req)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [n_req-1:0]        req_i,
  input  logic [n_req*lsize-1:0]  data_i,
`ifdef SHARED_REG_ARB_LOCK_EN
  input  logic [n_req-1:0]        lock_i,
`endif
  output logic [n_req-1:0]        ack_o,
  output logic                    ld_o,
  output logic [lsize-1:0]        d_o,
  output logic [IW-1:0]           gnt_idx_o,
  output logic                    busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [IW-1:0]       r_ptr;
  logic [IW-1:0]       r_gnt;
  logic [lsize-1:0]    r_d;
  logic [n_req-1:0]    r_ack;
  logic                r_ld;
  logic                r_busy;

  logic [n_req-1:0]    w_mask;
  logic [IW-1:0]       w_start;
  logic [IW-1:0]       w_win;
  logic                w_found;
  logic                w_lock;
  logic [n_req-1:0]    w_ack;
  logic                w_ld;
  logic                w_busy;
  logic                w_take;

  function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] idx);
    if (idx == IW'(n_req - 1)) begin
      inc_mod = '0;
    end else begin
      inc_mod = idx + IW'(1);
    end
  endfunction

`ifdef SHARED_REG_ARB_LOCK_EN
  assign w_lock = (r_state == S_ACK) && lock_i[r_gnt];
`else
  assign w_lock = 1'b0;
`endif

  // In ACK the finishing winner is masked and the search starts just past it
  always_comb begin
    int j;
    w_mask  = req_i;
    w_start = r_ptr;
    w_found = 1'b0;
    w_win   = '0;
    if (r_state == S_ACK) begin
      w_mask[r_gnt] = 1'b0;
      w_start       = inc_mod(r_gnt);
    end else begin
      w_start = r_ptr;
    end
    for (int i = 0; i < n_req; i++) begin
      j = int'(w_start) + i;
      if (j >= n_req) begin
        j = j - n_req;
      end else begin
        j = j;
      end
      if (!w_found && w_mask[IW'(j)]) begin
        w_found = 1'b1;
        w_win   = IW'(j);
      end else begin
        w_found = w_found;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: w_next = w_found ? S_LOAD : S_IDLE;
      S_LOAD: w_next = S_ACK;
      S_ACK: begin
        if (w_lock) begin
          w_next = S_IDLE;
        end else if (w_found) begin
          w_next = S_LOAD;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    w_ack  = '0;
    w_ld   = (w_next == S_LOAD);
    w_busy = (w_next != S_IDLE);
    w_take = (w_next == S_LOAD);
    if (w_next == S_ACK) begin
      w_ack[r_gnt] = 1'b1;
    end else begin
      w_ack = '0;
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Output registers, latched grant/data and round-robin pointer
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ack  <= '0;
      r_ld   <= 1'b0;
      r_busy <= 1'b0;
      r_d    <= '0;
      r_gnt  <= '0;
      r_ptr  <= '0;
    end else begin
      r_ack  <= w_ack;
      r_ld   <= w_ld;
      r_busy <= w_busy;
      if (w_take) begin
        r_d   <= data_i[w_win*lsize +: lsize];
        r_gnt <= w_win;
      end
      if (r_state == S_ACK) begin
        r_ptr <= w_lock ? r_gnt : inc_mod(r_gnt);
      end
    end
  end

  assign ack_o     = r_ack;
  assign ld_o      = r_ld;
  assign d_o       = r_d;
  assign gnt_idx_o = r_gnt;
  assign busy_o    = r_busy;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter (n_req=4, lsize=8): stimulus pushes
// expected writes, a negedge monitor checks every ld_o/ack_o it observes.
module tb_shared_reg_arbiter;

  logic        clk_i;
  logic        rst_i;
  logic [3:0]  req_i;
  logic [31:0] data_i;
  logic [3:0]  ack_o;
  logic        ld_o;
  logic [7:0]  d_o;
  logic [1:0]  gnt_idx_o;
  logic        busy_o;
`ifdef SHARED_REG_ARB_LOCK_EN
  logic [3:0]  lock_i;
`endif

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;
  logic mon_en;

  shared_reg_arbiter #(.lsize(8), .n_req(4)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .data_i    (data_i),
`ifdef SHARED_REG_ARB_LOCK_EN
    .lock_i    (lock_i),
`endif
    .ack_o     (ack_o),
    .ld_o      (ld_o),
    .d_o       (d_o),
    .gnt_idx_o (gnt_idx_o),
    .busy_o    (busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] idx, input logic [7:0] d);
    exp_t e;
    e.idx = idx;
    e.d   = d;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for ack to requester k, then drop its request
  task automatic wait_ack(input int k);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk_i);
      if (ack_o[k]) seen = 1'b1;
    end
    check($sformatf("ack_seen_req%0d", k), {31'd0, seen}, 32'd1);
    req_i[k] = 1'b0;
  endtask

  // Monitor: every ld_o pulse pops one expected write; the ack must follow next cycle
  logic       pend;
  logic [3:0] pend_vec;
  logic       prev_ld;
  always @(negedge clk_i) begin
    if (!mon_en || !rst_i) begin
      pend    = 1'b0;
      prev_ld = 1'b0;
    end else begin
      if (pend) begin
        check("ack_onehot", {28'd0, ack_o}, {28'd0, pend_vec});
      end else if (ack_o != 4'd0) begin
        check("ack_unexpected", {28'd0, ack_o}, 32'd0);
      end
      pend = 1'b0;
      if (ld_o) begin
        check("ld_not_consecutive", {31'd0, prev_ld}, 32'd0);
        if (exp_q.size() == 0) begin
          check("ld_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("d_o", {24'd0, d_o}, {24'd0, e.d});
          check("gnt_idx_o", {30'd0, gnt_idx_o}, {30'd0, e.idx});
          pend     = 1'b1;
          pend_vec = 4'b0001 << e.idx;
        end
      end
      prev_ld = ld_o;
    end
  end

  task automatic do_reset();
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    check("rst_ack", {28'd0, ack_o}, 32'd0);
    check("rst_ld", {31'd0, ld_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk_i);
    #3 rst_i = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    rst_i    = 1'b1;
    req_i    = 4'd0;
    data_i   = 32'd0;
`ifdef SHARED_REG_ARB_LOCK_EN
    lock_i   = 4'd0;
`endif
    // Reset asserted mid-cycle: outputs clear without waiting for an edge
    #12 rst_i = 1'b0;
    #1;
    check("rst_ack", {28'd0, ack_o}, 32'd0);
    check("rst_ld", {31'd0, ld_o}, 32'd0);
    check("rst_d", {24'd0, d_o}, 32'd0);
    check("rst_gnt", {30'd0, gnt_idx_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    mon_en = 1'b1;
    @(negedge clk_i);
    #3 rst_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      check("idle_ld", {31'd0, ld_o}, 32'd0);
      check("idle_busy", {31'd0, busy_o}, 32'd0);
    end

    // Single request from requester 1
    data_i[8 +: 8] = 8'hA5;
    push(2'd1, 8'hA5);
    req_i = 4'b0010;
    @(negedge clk_i);
    check("single_latency_ld", {31'd0, ld_o}, 32'd1);
    check("single_busy", {31'd0, busy_o}, 32'd1);
    wait_ack(1);
    @(negedge clk_i);
    check("single_d_hold", {24'd0, d_o}, 32'h0000_00A5);

    // Contention after reset: order 0,1,2,3
    do_reset();
    for (int k = 0; k < 4; k++) begin
      data_i[k*8 +: 8] = 8'h10 + 8'(k);
      push(2'(k), 8'h10 + 8'(k));
    end
    req_i = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_ack(k);
    end
    repeat (2) @(negedge clk_i);

    // Wrap-around: grant 2 leaves ptr=3, so 3 beats 0
    data_i = 32'h0BAD_C0DE;
    push(2'd2, 8'hAD);
    req_i = 4'b0100;
    wait_ack(2);
    @(negedge clk_i);
    data_i[24 +: 8] = 8'h3C;
    data_i[0 +: 8]  = 8'hC3;
    push(2'd3, 8'h3C);
    push(2'd0, 8'hC3);
    req_i = 4'b1001;
    wait_ack(3);
    wait_ack(0);
    repeat (2) @(negedge clk_i);

    // Reset during LOAD: write to requester 1 is lost, ptr returns to 0
    data_i[8 +: 8] = 8'h77;
    push(2'd1, 8'h77);
    req_i = 4'b0010;
    for (int c = 0; c < 10 && !ld_o; c++) @(negedge clk_i);
    check("abort_ld_seen", {31'd0, ld_o}, 32'd1);
    #2 rst_i = 1'b0;
    #1;
    check("abort_ld_drop", {31'd0, ld_o}, 32'd0);
    check("abort_ack", {28'd0, ack_o}, 32'd0);
    data_i[8 +: 8]  = 8'h61;
    data_i[16 +: 8] = 8'h62;
    push(2'd1, 8'h61);
    push(2'd2, 8'h62);
    req_i = 4'b0110;
    @(negedge clk_i);
    #3 rst_i = 1'b1;
    wait_ack(1);
    wait_ack(2);
    repeat (3) @(negedge clk_i);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
